spi_master: RTL
===============

Name: spi_master

Overview:
- Parametrised SPI master, successor to the fixed 8-bit mode-0 SPI interface.
- Adds configurable word width, all four CPOL/CPHA modes, MSB/LSB-first order and a programmable SCK divider.
- Adds multiple active-low chip selects with optional hold between words, plus a busy/done handshake.
- Sits between the CPU-side I/O decode and SD card, flash or other SPI peripherals.

Parameters:
- DW, 8, transfer word width in bits (2..32).
- CSN, 1, number of chip-select outputs (1..8).
- DIVW, 8, width of the SCK divider value.

Ports:
- clock  in  1  system clock; all state updates on its negative edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; the FSM, divider and shifter advance only when ce=1.
- io  in  1  start strobe; sampled when ce=1.
- d  in  DW  transmit word, latched at start.
- q  out  DW  last received word.
- div  in  DIVW  half-period of SCK in ce cycles, minus 1; latched at start.
- cpol, cpha, lsbf  in  1 each  SPI mode and bit order.
- csel  in  max(1,clog2(CSN))  chip-select index, latched at start.
- hold  in  1  keep CS asserted after this word; latched at start.
- rel  in  1  release a held CS while idle.
- busy  out  1  transfer in progress.
- done  out  1  one-clock completion pulse.
- ck  out  1  SPI clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- cs  out  CSN  active-low chip selects.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: q=0, busy=0, done=0, cs=all 1, ck=0, mosi=0, mode register=0, state=IDLE.
- Reset mid-transfer aborts immediately with no done pulse.
- Half-period tick: a divider counts ce cycles from 0 to the latched div, then wraps to 0 and issues a tick. With div=0 there is one tick per ce cycle.
- IDLE:
  - The mode register (cpol, cpha, lsbf) follows the inputs on every ce cycle.
  - ck = registered cpol.
  - io=1 with ce=1 starts a transfer: latch d, div, csel, hold and mode; drive cs[csel] low and all other cs high; busy=1 from the next clock; go to SETUP.
  - rel=1 with ce=1 and io=0 sets all cs high. If io and rel are both 1, start wins.
- SETUP: lasts one half-period with CS asserted and ck idle, giving CS-to-SCK setup. Then go to XFER.
- XFER:
  - 2*DW ticks. An edge counter ec runs 0..2*DW-1 and ck = cpol XOR (ec odd-phase) toggles on each tick.
  - mosi = sd[DW-1] when msb-first, sd[0] when lsbf.
  - cpha=0: the first bit is valid from SETUP; miso is sampled on leading edges and the shift happens on trailing edges.
  - cpha=1: shift on leading edges, sample on trailing edges.
  - Received bits enter rx in the order set by lsbf, so q always holds the word with bit 0 as the LSB.
  - On the last tick: q <= assembled rx word, done=1 for exactly one clock, go to END.
- END: lasts one half-period with ck=cpol. Then set cs all high if hold=0 (leave cs unchanged if hold=1), set busy=0, go to IDLE.
- io is ignored while busy=1. div, mode and d changes during busy have no effect.
- A new start while a CS is held with a different csel switches CS at acceptance; no glitch on other lines.
- If csel ≥ CSN, no CS is asserted but the transfer runs normally.
- done is cleared on every clock where it is not set, so it is a single-cycle pulse regardless of ce.
- Compatibility: DW=8, div=0, mode 0, msb-first reproduces the legacy timing, except for the added SETUP/END half-periods.

Decomposition:
- Package spi_pkg: FSM state encoding (IDLE, SETUP, XFER, END), mode bit indices, clog2 function for the csel width.
- One sub-module, spi_clkdiv: the ce-qualified divider producing the tick, with load/clear on start.
- The shift/sample logic and FSM stay in spi_master.

Test Plan:
- Mode 0, DW=8, div=0, d=0xA5, miso looped to mosi → q=0xA5, done one clock, 8 ck rising edges, cs[0] low only while busy.
- Mode 3, div=3, d=0x3C, miso driven 0x96 msb-first → ck idle high, half-period 4 ce cycles, q=0x96.
- lsbf=1, DW=16, d=0x8001, slave returns 0x1234 lsb-first → mosi sequence 1,0,…,0,1; q=0x1234.
- CSN=4, csel=2, hold=1, two back-to-back words → cs[2] low across both words and still low after; rel pulse → cs=4'b1111.
- io pulsed while busy and reset asserted mid-XFER → second start ignored; after reset cs=all 1, busy=0, done never pulses.
- ce low for random stretches in mode 1 → q identical to the ce=1 run; ck edges only on ce cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, mode bit indices and width helpers for the SPI master
package spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_END   = 2'd3;

  localparam int MODE_CPOL = 0;
  localparam int MODE_CPHA = 1;
  localparam int MODE_LSBF = 2;

  typedef logic [2:0] mode_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single chip select still needs a one-bit index port.
  function automatic int cselw(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - CPU-side control and SPI pin bundle of the SPI master
interface spi_master_if #(
  parameter int DW   = 8,
  parameter int CSN  = 1,
  parameter int DIVW = 8
);
  import spi_pkg::*;
  localparam int CSW = cselw(CSN);

  logic            ce;
  logic            io;
  logic [DW-1:0]   d;
  logic [DW-1:0]   q;
  logic [DIVW-1:0] div;
  logic            cpol;
  logic            cpha;
  logic            lsbf;
  logic [CSW-1:0]  csel;
  logic            hold;
  logic            rel;
  logic            busy;
  logic            done;
  logic            ck;
  logic            mosi;
  logic            miso;
  logic [CSN-1:0]  cs;

  modport master (
    input  ce, io, d, div, cpol, cpha, lsbf, csel, hold, rel, miso,
    output q, busy, done, ck, mosi, cs
  );

  modport slave (
    output ce, io, d, div, cpol, cpha, lsbf, csel, hold, rel, miso,
    input  q, busy, done, ck, mosi, cs
  );

endinterface

// File: rtl/spi_clkdiv.sv
// rtl/spi_clkdiv.sv - ce-qualified half-period divider; loads the divisor and clears on start
module spi_clkdiv #(
  parameter int DIVW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ce,
  input  logic            load,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  output logic            tick
);

  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] div_l;

  assign tick = en && ce && (cnt == div_l);

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      div_l <= '0;
    end else if (load) begin
      cnt   <= '0;
      div_l <= div;
    end else if (en && ce) begin
      cnt <= (cnt == div_l) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - parametrised SPI master: word width, four modes, bit order, divider, chip selects
module spi_master
  import spi_pkg::*;
#(
  parameter int DW   = 8,
  parameter int CSN  = 1,
  parameter int DIVW = 8
) (
  input  logic         clock,
  input  logic         reset,
  spi_master_if.master bus
);

  localparam int CSW = cselw(CSN);
  localparam int ECW = clog2(2 * DW);

  logic [1:0]     st;
  mode_t          mode;
  logic [DW-1:0]  sd;
  logic [DW-1:0]  rx;
  logic [DW-1:0]  rx_nx;
  logic [ECW-1:0] ec;
  logic           hold_l;
  logic [DW-1:0]  q_r;
  logic           busy_r;
  logic           done_r;
  logic           ck_r;
  logic [CSN-1:0] cs_r;
  logic [CSN-1:0] cs_sel;
  logic           tick;
  logic           start;
  logic           last;
  logic           smp;
  logic           shift;

  assign start = (st == ST_IDLE) && bus.ce && bus.io;
  assign last  = (ec == ECW'(2 * DW - 1));
  // Even ec is a leading edge; cpha picks whether that edge samples or shifts.
  assign smp   = ~ec[0] ^ mode[MODE_CPHA];
  // With cpha=1 the first leading edge only launches the already-loaded MSB/LSB.
  assign shift = ~smp && (ec != '0);
  assign rx_nx = mode[MODE_LSBF] ? {bus.miso, rx[DW-1:1]} : {rx[DW-2:0], bus.miso};

  always_comb begin
    cs_sel = '1;
    for (int i = 0; i < CSN; i++) begin
      cs_sel[i] = (CSW'(i) != bus.csel);
    end
  end

  spi_clkdiv #(.DIVW(DIVW)) u_clkdiv (
    .clock (clock),
    .reset (reset),
    .ce    (bus.ce),
    .load  (start),
    .en    (busy_r),
    .div   (bus.div),
    .tick  (tick)
  );

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      st     <= ST_IDLE;
      mode   <= '0;
      sd     <= '0;
      rx     <= '0;
      ec     <= '0;
      hold_l <= 1'b0;
      q_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ck_r   <= 1'b0;
      cs_r   <= '1;
    end else begin
      done_r <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (bus.ce) begin
            mode <= {bus.lsbf, bus.cpha, bus.cpol};
            ck_r <= bus.cpol;
            if (bus.io) begin
              sd     <= bus.d;
              rx     <= '0;
              ec     <= '0;
              hold_l <= bus.hold;
              cs_r   <= cs_sel;
              busy_r <= 1'b1;
              st     <= ST_SETUP;
            end else if (bus.rel) begin
              cs_r <= '1;
            end
          end
        end
        ST_SETUP: begin
          if (tick) st <= ST_XFER;
        end
        ST_XFER: begin
          if (tick) begin
            ck_r <= ~ck_r;
            ec   <= ec + 1'b1;
            if (smp) rx <= rx_nx;
            if (shift) sd <= mode[MODE_LSBF] ? (sd >> 1) : (sd << 1);
            if (last) begin
              q_r    <= smp ? rx_nx : rx;
              done_r <= 1'b1;
              st     <= ST_END;
            end
          end
        end
        ST_END: begin
          if (tick) begin
            if (!hold_l) cs_r <= '1;
            busy_r <= 1'b0;
            st     <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.ck   = ck_r;
  assign bus.mosi = mode[MODE_LSBF] ? sd[0] : sd[DW-1];
  assign bus.cs   = cs_r;

endmodule
